// File: rtl/rx_valid_window_gen.sv
// rx_valid_window_gen
//
// Valid-strobe generator between the Viterbi decoder output and the descrambler
// input. A start pulse latches the modulation (rate[3:2]) and the frame length,
// then the block waits out the modulation's pipeline latency and emits a
// periodic ON/OFF valid window marking payload bits.
//
// Ports:
//   Clk            clock, all logic on the rising edge
//   reset          synchronous, active-low reset
//   start_i        one-cycle frame start; also restarts an active frame
//   rate_i         802.11a RATE field, only rate_i[3:2] is used (sampled on start)
//   frame_bits_i   number of valid bits to emit, 0 = unlimited (sampled on start)
//   hold_i         stall: freezes all counters and suppresses valid
//   valid_out_o    registered descrambler-input valid
//   busy_o         high while a frame is in progress (latency or window phase)
//   done_o         one-cycle pulse on the last valid bit of a bounded frame
//   bit_count_o    number of valid_out_o highs in the current frame

module rx_valid_window_gen #(
  parameter int unsigned LAT_BPSK  = 231,
  parameter int unsigned LAT_QPSK  = 279,
  parameter int unsigned LAT_16QAM = 375,
  parameter int unsigned LAT_64QAM = 471,
  parameter int unsigned LAT_W     = 10,
  parameter int unsigned ON_LEN    = 24,
  parameter int unsigned PERIOD    = 48,
  parameter int unsigned BC_W      = 16
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [3:0]      rate_i,
  input  logic [BC_W-1:0] frame_bits_i,
  input  logic            hold_i,
  output logic            valid_out_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [BC_W-1:0] bit_count_o
);

  localparam int unsigned PhaseW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  // ON_LEN may equal PERIOD, so the ON threshold needs one extra bit.
  localparam logic [PhaseW:0]   OnLen    = (PhaseW + 1)'(ON_LEN);
  localparam logic [PhaseW-1:0] PhaseMax = PhaseW'(PERIOD - 1);

  localparam logic [LAT_W-1:0] LatBpsk  = LAT_W'(LAT_BPSK);
  localparam logic [LAT_W-1:0] LatQpsk  = LAT_W'(LAT_QPSK);
  localparam logic [LAT_W-1:0] Lat16Qam = LAT_W'(LAT_16QAM);
  localparam logic [LAT_W-1:0] Lat64Qam = LAT_W'(LAT_64QAM);

  typedef enum logic [1:0] {
    StIdle,
    StLatency,
    StWindow
  } state_e;

  state_e            state_q;
  logic [1:0]        mod_q;
  logic [BC_W-1:0]   frame_bits_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [PhaseW-1:0] phase_q;
  logic              valid_q;
  logic              done_q;
  logic [BC_W-1:0]   bit_count_q;

  logic [LAT_W-1:0]  lat_sel;
  logic              on_phase;
  logic [BC_W-1:0]   bc_plus1;
  logic [BC_W-1:0]   bc_inc;
  logic              last_bit;
  logic              unused_rate;

  // Only the modulation bits of RATE select a latency.
  assign unused_rate = ^rate_i[1:0];

  always_comb begin
    lat_sel = Lat64Qam;
    case (mod_q)
      2'b11:   lat_sel = LatBpsk;
      2'b01:   lat_sel = LatQpsk;
      2'b10:   lat_sel = Lat16Qam;
      default: lat_sel = Lat64Qam;
    endcase
  end

  always_comb begin
    on_phase = {1'b0, phase_q} < OnLen;
    bc_plus1 = bit_count_q + 1'b1;
    // Saturate so an unlimited frame never wraps back to zero.
    bc_inc   = (bit_count_q == '1) ? bit_count_q : bc_plus1;
    last_bit = (frame_bits_q != '0) && (bc_plus1 == frame_bits_q);
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      mod_q        <= '0;
      frame_bits_q <= '0;
      lat_cnt_q    <= '0;
      phase_q      <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      bit_count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        // Start wins over hold and aborts any frame in progress.
        mod_q        <= rate_i[3:2];
        frame_bits_q <= frame_bits_i;
        lat_cnt_q    <= '0;
        phase_q      <= '0;
        bit_count_q  <= '0;
        valid_q      <= 1'b0;
        state_q      <= StLatency;
      end else begin
        unique case (state_q)
          StIdle: begin
            valid_q <= 1'b0;
          end
          StLatency: begin
            valid_q <= 1'b0;
            if (!hold_i) begin
              if (lat_cnt_q < lat_sel) begin
                lat_cnt_q <= lat_cnt_q + 1'b1;
              end else begin
                phase_q <= '0;
                state_q <= StWindow;
              end
            end
          end
          StWindow: begin
            if (hold_i) begin
              valid_q <= 1'b0;
            end else begin
              valid_q <= on_phase;
              phase_q <= (phase_q == PhaseMax) ? '0 : phase_q + 1'b1;
              if (on_phase) begin
                bit_count_q <= bc_inc;
                if (last_bit) begin
                  done_q  <= 1'b1;
                  state_q <= StIdle;
                end
              end
            end
          end
          default: begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign valid_out_o = valid_q;
  assign done_o      = done_q;
  assign bit_count_o = bit_count_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_rx_valid_window_gen.sv
module tb_rx_valid_window_gen;

  logic        Clk;
  logic        reset;
  logic        start;
  logic [3:0]  rate;
  logic [15:0] frame_bits;
  logic        hold;

  logic        valid0, busy0, done0;
  logic [15:0] bc0;
  logic        valid1, busy1, done1;
  logic [7:0]  bc1;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Default build.
  rx_valid_window_gen dut0 (
    .Clk          (Clk),
    .reset        (reset),
    .start_i      (start),
    .rate_i       (rate),
    .frame_bits_i (frame_bits),
    .hold_i       (hold),
    .valid_out_o  (valid0),
    .busy_o       (busy0),
    .done_o       (done0),
    .bit_count_o  (bc0)
  );

  // Always-on window with a narrow counter to reach saturation quickly.
  rx_valid_window_gen #(
    .ON_LEN (8),
    .PERIOD (8),
    .BC_W   (8)
  ) dut1 (
    .Clk          (Clk),
    .reset        (reset),
    .start_i      (start),
    .rate_i       (rate),
    .frame_bits_i (frame_bits[7:0]),
    .hold_i       (hold),
    .valid_out_o  (valid1),
    .busy_o       (busy1),
    .done_o       (done1),
    .bit_count_o  (bc1)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Behavioural model: k counts non-hold edges since start; the window
  // begins at k = LAT+2 and position (k-LAT-2) mod PERIOD decides ON/OFF.
  bit m_act[2];
  bit m_valid[2];
  bit m_done[2];
  int m_k[2];
  int m_lat[2];
  int m_bits[2];
  int m_lim[2];

  function automatic int lat_of(input logic [3:0] r);
    case (r[3:2])
      2'b11:   return 231;
      2'b01:   return 279;
      2'b10:   return 375;
      default: return 471;
    endcase
  endfunction

  task automatic model_update(input logic rst, input logic st, input logic [3:0] rt,
                              input logic [15:0] fb, input logic hd);
    for (int i = 0; i < 2; i++) begin
      int per  = (i == 0) ? 48 : 8;
      int onl  = (i == 0) ? 24 : 8;
      int mask = (i == 0) ? 65535 : 255;
      m_valid[i] = 1'b0;
      m_done[i]  = 1'b0;
      if (!rst) begin
        m_act[i]  = 1'b0;
        m_bits[i] = 0;
        m_k[i]    = 0;
      end else if (st) begin
        m_act[i]  = 1'b1;
        m_k[i]    = 0;
        m_bits[i] = 0;
        m_lat[i]  = lat_of(rt);
        m_lim[i]  = int'(fb) & mask;
      end else if (m_act[i] && !hd) begin
        m_k[i]++;
        if (m_k[i] >= m_lat[i] + 2 && ((m_k[i] - m_lat[i] - 2) % per) < onl) begin
          m_valid[i] = 1'b1;
          if (m_bits[i] < mask) m_bits[i]++;
          if (m_lim[i] != 0 && m_bits[i] == m_lim[i]) begin
            m_done[i] = 1'b1;
            m_act[i]  = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic compare_cycle();
    for (int i = 0; i < 2; i++) begin
      logic        gv, gb, gd;
      logic [15:0] gbc;
      if (i == 0) begin
        gv = valid0; gb = busy0; gd = done0; gbc = bc0;
      end else begin
        gv = valid1; gb = busy1; gd = done1; gbc = {8'h00, bc1};
      end
      checks++;
      if (gv !== m_valid[i] || gb !== m_act[i] || gd !== m_done[i] ||
          gbc !== 16'(m_bits[i])) begin
        errors++;
        $display("FAIL model_cmp inst%0d edge %0d: got v=%b busy=%b done=%b bc=%0d, exp v=%b busy=%b done=%b bc=%0d",
                 i, edge_n, gv, gb, gd, gbc, m_valid[i], m_act[i], m_done[i], m_bits[i]);
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Drive one cycle, advance the model on the edge, compare just after it.
  task automatic step(input logic rst, input logic st, input logic [3:0] rt,
                      input logic [15:0] fb, input logic hd);
    reset = rst; start = st; rate = rt; frame_bits = fb; hold = hd;
    @(posedge Clk);
    edge_n++;
    model_update(rst, st, rt, fb, hd);
    #1;
    compare_cycle();
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 4'($urandom), 16'($urandom), 1'b0);
  endtask

  // Bounded BPSK frame of 30 bits with optional holds in latency and window.
  task automatic bounded(input string tag, input int hl, input int hw, input int exp_done);
    int done_rel = -1, ndone = 0, nhold_valid = 0;
    step(1'b1, 1'b1, 4'b1101, 16'd30, 1'b1);
    for (int i = 1; i <= 320; i++) begin
      logic hd;
      hd = (i >= 50 && i < 50 + hl) || (i >= 245 && i < 245 + hw);
      step(1'b1, 1'b0, 4'($urandom), 16'($urandom), hd);
      if (done0) begin ndone++; done_rel = i; end
      if (hd && valid0) nhold_valid++;
    end
    chk({tag, "_done_edge"}, done_rel, exp_done);
    chk({tag, "_done_count"}, ndone, 1);
    chk({tag, "_valid_in_hold"}, nhold_valid, 0);
    chk({tag, "_final_bits"}, int'(bc0), 30);
    chk({tag, "_busy_after"}, int'(busy0), 0);
    chk({tag, "_valid_after"}, int'(valid0), 0);
  endtask

  initial begin
    int first0, first1, n1, v400, v401, v424, v425, bc448, ndone, bc_rs, first_rs;
    reset = 1'b0; start = 1'b0; rate = '0; frame_bits = '0; hold = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom));
      chk("reset_valid", int'(valid0), 0);
      chk("reset_busy", int'(busy0), 0);
      chk("reset_bits", int'(bc0), 0);
    end
    idle_step();

    // 16-QAM, unlimited frame.
    step(1'b1, 1'b1, 4'b1001, 16'd0, 1'b0);
    first0 = -1; first1 = -1; n1 = 0;
    v400 = -1; v401 = -1; v424 = -1; v425 = -1; bc448 = -1;
    for (int i = 1; i <= 700; i++) begin
      idle_step();
      if (valid0 && first0 < 0) first0 = i;
      if (valid1 && first1 < 0) first1 = i;
      if (valid1) n1++;
      if (i == 400) v400 = int'(valid0);
      if (i == 401) v401 = int'(valid0);
      if (i == 424) v424 = int'(valid0);
      if (i == 425) v425 = int'(valid0);
      if (i == 448) bc448 = int'(bc0);
    end
    chk("qam16_first_valid", first0, 377);
    chk("qam16_on_400", v400, 1);
    chk("qam16_off_401", v401, 0);
    chk("qam16_off_424", v424, 0);
    chk("qam16_on_425", v425, 1);
    chk("qam16_bits_448", bc448, 48);
    chk("full_on_first_valid", first1, 377);
    chk("full_on_valid_cycles", n1, 324);
    chk("full_on_saturated", int'(bc1), 255);
    step(1'b0, 1'b0, 4'b0, 16'd0, 1'b0);
    chk("midframe_reset_busy", int'(busy0), 0);
    idle_step();

    bounded("bpsk30", 0, 0, 286);
    bounded("bpsk30_hold", 5, 3, 294);

    // Restart QPSK frame with a 64-QAM start at edge 300.
    step(1'b1, 1'b1, 4'b0101, 16'd0, 1'b0);
    ndone = 0; bc_rs = -1; first_rs = -1;
    for (int i = 1; i <= 790; i++) begin
      if (i == 300) step(1'b1, 1'b1, 4'b0001, 16'd0, 1'b0);
      else idle_step();
      if (done0) ndone++;
      if (i == 300) bc_rs = int'(bc0);
      if (i > 300 && valid0 && first_rs < 0) first_rs = i;
    end
    chk("restart_done_count", ndone, 0);
    chk("restart_bits_cleared", bc_rs, 0);
    chk("restart_first_valid", first_rs, 773);

    // Start on the edge that would have asserted done.
    step(1'b1, 1'b1, 4'b1101, 16'd30, 1'b0);
    ndone = 0; first_rs = -1;
    for (int i = 1; i <= 540; i++) begin
      if (i == 286) begin
        step(1'b1, 1'b1, 4'b1101, 16'd5, 1'b0);
        chk("start_on_done_no_done", int'(done0), 0);
        chk("start_on_done_busy", int'(busy0), 1);
      end else begin
        idle_step();
      end
      if (done0) begin ndone++; first_rs = i; end
    end
    chk("start_on_done_count", ndone, 1);
    chk("start_on_done_second_done", first_rs, 523);

    // Random traffic.
    for (int i = 0; i < 8000; i++) begin
      logic rst, st;
      rst = ($urandom % 3000) != 0;
      st  = m_act[0] ? (($urandom % 700) == 0) : (($urandom % 20) == 0);
      step(rst, st, 4'($urandom),
           (($urandom % 4) == 0) ? 16'd0 : 16'($urandom_range(1, 60)),
           ($urandom % 8) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
